// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks (PISO and the serial adder control path).
package serial_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } serial_state_e;

endpackage

// File: rtl/param_piso.sv
// Parameterised parallel-in/serial-out shifter with valid/ready load handshake and
// per-bit serial consume enable; supports zero-bubble back-to-back words.
module param_piso
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic             s_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic shifting;
    logic last_bit;
    logic last_taken;

    assign shifting   = (state_q == StShift);
    assign last_bit   = shifting && (cnt_q == LastCnt);
    assign last_taken = last_bit && s_en;

    // Outputs come only from registered state, so d_in never reaches s_out.
    always_comb begin
        s_valid  = shifting;
        busy     = shifting;
        s_last   = last_bit;
        in_ready = !shifting || last_taken;
        s_out    = 1'b0;
        if (shifting) begin
            s_out = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StShift;
                    shreg_d = d_in;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (s_en) begin
                    if (last_bit) begin
                        // Reload immediately when the next word is waiting.
                        if (in_valid) begin
                            shreg_d = d_in;
                            cnt_d   = '0;
                        end else begin
                            state_d = StIdle;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_param_piso.sv
// Self-checking bench for param_piso: LSB-first and MSB-first instances driven in parallel,
// checked every cycle against a word/bit-index model plus literal bit sequences.
module tb_param_piso;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] d_in;
    logic         s_en;

    logic in_ready_l, s_out_l, s_valid_l, s_last_l, busy_l;
    logic in_ready_m, s_out_m, s_valid_m, s_last_m, busy_m;

    param_piso #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready_l),
        .d_in     (d_in),
        .s_en     (s_en),
        .s_out    (s_out_l),
        .s_valid  (s_valid_l),
        .s_last   (s_last_l),
        .busy     (busy_l)
    );

    param_piso #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready_m),
        .d_in     (d_in),
        .s_en     (s_en),
        .s_out    (s_out_m),
        .s_valid  (s_valid_m),
        .s_last   (s_last_m),
        .busy     (busy_m)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the word being sent and which bit index is on the wire.
    bit           m_known  = 1'b0;
    bit           m_active = 1'b0;
    logic [W-1:0] m_word   = '0;
    int           m_idx    = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_known  <= 1'b1;
            m_active <= 1'b0;
            m_idx    <= 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1'b1;
                m_word   <= d_in;
                m_idx    <= 0;
            end
        end else if (s_en) begin
            if (m_idx == W - 1) begin
                if (in_valid) begin
                    m_word <= d_in;
                    m_idx  <= 0;
                end else begin
                    m_active <= 1'b0;
                end
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    bit cap_l[$];
    bit cap_m[$];
    int last_cnt = 0;

    always @(negedge clk) begin
        logic e_last, e_ready, e_bit_l, e_bit_m;
        if (m_known) begin
            e_last  = m_active && (m_idx == W - 1);
            e_ready = !m_active || (e_last && s_en);
            e_bit_l = m_active ? m_word[m_idx] : 1'b0;
            e_bit_m = m_active ? m_word[W-1-m_idx] : 1'b0;
            chk("lsb_s_valid", 32'(s_valid_l), 32'(m_active));
            chk("lsb_busy", 32'(busy_l), 32'(m_active));
            chk("lsb_s_last", 32'(s_last_l), 32'(e_last));
            chk("lsb_in_ready", 32'(in_ready_l), 32'(e_ready));
            chk("lsb_s_out", 32'(s_out_l), 32'(e_bit_l));
            chk("msb_s_valid", 32'(s_valid_m), 32'(m_active));
            chk("msb_s_last", 32'(s_last_m), 32'(e_last));
            chk("msb_in_ready", 32'(in_ready_m), 32'(e_ready));
            chk("msb_s_out", 32'(s_out_m), 32'(e_bit_m));
            if (s_valid_l && s_en) begin
                cap_l.push_back(s_out_l);
                if (s_last_l) last_cnt++;
            end
            if (s_valid_m && s_en) cap_m.push_back(s_out_m);
        end
    end

    // Packs bits in emission order, first bit ending up most significant.
    task automatic chk_seq(input string name, input bit q[$], input int n,
                           input logic [31:0] exp);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        chk({name, "_len"}, 32'(q.size()), 32'(n));
        chk(name, v, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_caps();
        cap_l.delete();
        cap_m.delete();
        last_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; d_in = '0; s_en = 1'b0;
        step(2);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready_l), 32'd1);
        chk("rst_s_valid", 32'(s_valid_l), 32'd0);
        chk("rst_s_out", 32'(s_out_l), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);

        // Single word 1011, continuous consume.
        clear_caps();
        in_valid = 1'b1; d_in = 4'b1011; s_en = 1'b1;
        step(1);
        in_valid = 1'b0;
        chk("w1_first_valid", 32'(s_valid_l), 32'd1);
        step(3);
        chk("w1_last_c4", 32'(s_last_l), 32'd1);
        chk("w1_ready_c4", 32'(in_ready_l), 32'd1);
        step(1);
        chk("w1_idle_c5", 32'(busy_l), 32'd0);
        chk_seq("w1_lsb", cap_l, 4, 32'b1101);
        chk_seq("w1_msb", cap_m, 4, 32'b1011);

        // 0110 with a three-cycle stall after the first bit.
        clear_caps();
        in_valid = 1'b1; d_in = 4'b0110;
        step(1);
        in_valid = 1'b0;
        step(1);
        s_en = 1'b0;
        step(2);
        chk("stall_s_out", 32'(s_out_l), 32'd1);
        chk("stall_s_valid", 32'(s_valid_l), 32'd1);
        step(1);
        s_en = 1'b1;
        step(4);
        chk_seq("stall_lsb", cap_l, 4, 32'b0110);

        // Back-to-back A then 5 with in_valid held.
        clear_caps();
        in_valid = 1'b1; d_in = 4'hA;
        step(1);
        d_in = 4'h5;
        step(4);
        in_valid = 1'b0;
        step(5);
        chk_seq("b2b_lsb", cap_l, 8, 32'b01011010);
        chk_seq("b2b_msb", cap_m, 8, 32'b10100101);
        chk("b2b_last_cnt", 32'(last_cnt), 32'd2);

        // Reset after two bits of F, with in_valid asserted alongside reset.
        in_valid = 1'b1; d_in = 4'hF;
        step(1);
        in_valid = 1'b0;
        step(2);
        reset = 1'b1; in_valid = 1'b1; d_in = 4'h3;
        step(1);
        reset = 1'b0; in_valid = 1'b0;
        chk("abort_s_valid", 32'(s_valid_l), 32'd0);
        chk("abort_in_ready", 32'(in_ready_l), 32'd1);
        chk("abort_s_out", 32'(s_out_l), 32'd0);
        clear_caps();
        step(2);
        chk("abort_quiet_len", 32'(cap_l.size()), 32'd0);
        in_valid = 1'b1; d_in = 4'h3;
        step(1);
        in_valid = 1'b0;
        step(5);
        chk_seq("abort_lsb", cap_l, 4, 32'b1100);
        chk_seq("abort_msb", cap_m, 4, 32'b0011);

        // Spurious in_valid mid-word on 9.
        clear_caps();
        in_valid = 1'b1; d_in = 4'h9;
        step(1);
        in_valid = 1'b0;
        step(1);
        in_valid = 1'b1; d_in = 4'h0;
        chk("ignore_in_ready", 32'(in_ready_l), 32'd0);
        step(1);
        in_valid = 1'b0;
        step(3);
        chk_seq("ignore_lsb", cap_l, 4, 32'b1001);
        chk_seq("ignore_msb", cap_m, 4, 32'b1001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
